// File: rtl/lock_uart_defs.sv
// Shared UART definitions for the lock: receiver/transmitter state encodings
// and the default bit period for 9600 baud from the 12 MHz hwclk.
package lock_uart_defs;

    localparam int DEFAULT_CLKS_PER_BIT = 1250;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high
// line does not look like a falling edge coming out of reset.
module sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a one-entry holding register (valid/ready), plus
// one-cycle frame-error and overrun pulses.
module uart_rx_8n1
    import lock_uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       ftdi_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            deliver;

    sync2 u_sync (
        .clk_i   (hwclk),
        .rst_n_i (rst_n),
        .d_i     (ftdi_rx),
        .q_o     (rx_s)
    );

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame sequencing: every sample point is the last count of its interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A byte consumed in the delivery cycle frees the slot for the new one.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != RX_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 using a short bit period so every
// scenario fits in a brief run.
module tb_uart_rx_8n1;

    localparam int C = 64;
    localparam int H = C / 2;
    localparam int RISE_LAT = 3 + H + 9 * C;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       expValid;
        logic [7:0] expData;
        int         expFerr;
    } vector_t;

    logic       hwclk = 1'b0;
    logic       rst_n;
    logic       ftdi_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int cycleCount = 0;
    int edgeCycle = 0;
    int riseCycle = 0;
    int ferrCnt = 0;
    int ovrCnt = 0;
    int busyCnt = 0;
    int validCnt = 0;
    logic prevValid = 1'b0;
    logic [7:0] accepted[$];
    vector_t vectors[6];

    uart_rx_8n1 #(.CLKS_PER_BIT(C)) dut (
        .hwclk     (hwclk),
        .rst_n     (rst_n),
        .ftdi_rx   (ftdi_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cycleCount <= cycleCount + 1;

    always @(negedge hwclk) begin
        if (frame_err) ferrCnt++;
        if (overrun) ovrCnt++;
        if (rx_busy) busyCnt++;
        if (rx_valid) validCnt++;
        if (rx_valid && rx_ready) accepted.push_back(rx_data);
        if (rx_valid && !prevValid) riseCycle = cycleCount;
        prevValid = rx_valid;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic clearCounts();
        ferrCnt = 0;
        ovrCnt = 0;
        busyCnt = 0;
        validCnt = 0;
        accepted.delete();
    endtask

    task automatic driveBit(input logic v);
        ftdi_rx = v;
        repeat (C) tick();
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int lowHold);
        edgeCycle = cycleCount;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
        driveBit(stopBit);
        if (!stopBit) repeat (lowHold) tick();
        ftdi_rx = 1'b1;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic applyStimulus(input vector_t v, input int n);
        string tag;
        clearCounts();
        sendFrame(v.data, v.stopBit, 0);
        repeat (8) tick();
        @(negedge hwclk);
        tag = $sformatf("vec%0d", n);
        checkOutput({tag, "_valid"}, 32'(rx_valid), 32'(v.expValid));
        checkOutput({tag, "_data"}, 32'(rx_data), 32'(v.expData));
        checkOutput({tag, "_ferr"}, 32'(ferrCnt), 32'(v.expFerr));
        checkOutput({tag, "_ovr"}, 32'(ovrCnt), 32'd0);
        consume();
        checkOutput({tag, "_cleared"}, 32'(rx_valid), 32'd0);
        tick();
    endtask

    initial begin
        vectors[0] = '{8'h35, 1'b1, 1'b1, 8'h35, 0};
        vectors[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vectors[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vectors[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vectors[4] = '{8'hA5, 1'b0, 1'b0, 8'h80, 1};
        vectors[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};

        rst_n = 1'b0;
        ftdi_rx = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(negedge hwclk);
        checkOutput("rst_data", 32'(rx_data), 32'h00);
        checkOutput("rst_flags", {27'd0, rx_valid, rx_busy, frame_err, overrun, 1'b0}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 6; i++) applyStimulus(vectors[i], i);

        // Single byte latency and hold-until-ready
        clearCounts();
        sendFrame(8'h35, 1'b1, 0);
        repeat (4) tick();
        @(negedge hwclk);
        checkOutput("lat_rise", 32'(riseCycle - edgeCycle), 32'(RISE_LAT));
        checkOutput("lat_data", 32'(rx_data), 32'h35);
        repeat (50) tick();
        @(negedge hwclk);
        checkOutput("lat_held", 32'(rx_valid), 32'd1);
        consume();
        checkOutput("lat_cleared", 32'(rx_valid), 32'd0);
        tick();

        // Glitch shorter than half a bit
        clearCounts();
        ftdi_rx = 1'b0;
        repeat (15) tick();
        ftdi_rx = 1'b1;
        repeat (3 * C) tick();
        @(negedge hwclk);
        checkOutput("glitch_busy", 32'(busyCnt), 32'(H));
        checkOutput("glitch_valid", 32'(validCnt), 32'd0);
        checkOutput("glitch_ferr", 32'(ferrCnt), 32'd0);
        tick();

        // Framing error with the line held low afterwards
        clearCounts();
        sendFrame(8'hA5, 1'b0, 150);
        checkOutput("ferr_busy", 32'(rx_busy), 32'd1);
        checkOutput("ferr_count", 32'(ferrCnt), 32'd1);
        checkOutput("ferr_valid", 32'(validCnt), 32'd0);
        repeat (8) tick();
        @(negedge hwclk);
        checkOutput("ferr_idle", 32'(rx_busy), 32'd0);
        tick();
        sendFrame(8'h5A, 1'b1, 0);
        repeat (4) tick();
        @(negedge hwclk);
        checkOutput("ferr_next_data", 32'(rx_data), 32'h5A);
        checkOutput("ferr_next_valid", 32'(rx_valid), 32'd1);
        consume();
        tick();

        // Overrun: second byte dropped
        clearCounts();
        sendFrame(8'h11, 1'b1, 0);
        sendFrame(8'h22, 1'b1, 0);
        repeat (4) tick();
        @(negedge hwclk);
        checkOutput("ovr_count", 32'(ovrCnt), 32'd1);
        checkOutput("ovr_data", 32'(rx_data), 32'h11);
        checkOutput("ovr_valid", 32'(rx_valid), 32'd1);
        checkOutput("ovr_ferr", 32'(ferrCnt), 32'd0);
        consume();
        tick();

        // Back-to-back frames with ready held high
        clearCounts();
        rx_ready = 1'b1;
        sendFrame(8'h01, 1'b1, 0);
        sendFrame(8'h02, 1'b1, 0);
        sendFrame(8'h03, 1'b1, 0);
        repeat (4) tick();
        @(negedge hwclk);
        rx_ready = 1'b0;
        checkOutput("b2b_valid_cycles", 32'(validCnt), 32'd3);
        checkOutput("b2b_count", 32'(accepted.size()), 32'd3);
        if (accepted.size() == 3) begin
            checkOutput("b2b_byte0", 32'(accepted[0]), 32'h01);
            checkOutput("b2b_byte1", 32'(accepted[1]), 32'h02);
            checkOutput("b2b_byte2", 32'(accepted[2]), 32'h03);
        end
        checkOutput("b2b_ovr", 32'(ovrCnt), 32'd0);
        checkOutput("b2b_ferr", 32'(ferrCnt), 32'd0);
        tick();

        // Reset during bit 4 of 0xFF
        clearCounts();
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        ftdi_rx = 1'b1;
        repeat (H) tick();
        rst_n = 1'b0;
        repeat (10) tick();
        @(negedge hwclk);
        checkOutput("mrst_data", 32'(rx_data), 32'h00);
        checkOutput("mrst_flags", {27'd0, rx_valid, rx_busy, frame_err, overrun, 1'b0}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (4 * C) tick();
        @(negedge hwclk);
        checkOutput("mrst_no_byte", 32'(validCnt), 32'd0);
        checkOutput("mrst_ferr", 32'(ferrCnt), 32'd0);
        tick();
        sendFrame(8'h66, 1'b1, 0);
        repeat (4) tick();
        @(negedge hwclk);
        checkOutput("mrst_next_data", 32'(rx_data), 32'h66);
        checkOutput("mrst_next_valid", 32'(rx_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
